// File: rtl/stp_load_sequencer.sv
// -----------------------------------------------------------------------------
// stp_load_sequencer
//
// Purpose:
//   Steers a serial bit stream into a bank of NUM_SAMPLES serial-to-parallel
//   shift registers, SAMPLE_WIDTH bits per lane. Once every lane is full, the
//   bank is frozen and offered to the FFT core as one frame.
//
// Optional feature (compile-time macro STP_AUTO_REARM_EN):
//   When defined, the frame handshake goes straight back to LOAD with the
//   counters at zero. A serial bit present in the handshake cycle is taken as
//   bit 0 of lane 0. When undefined, the handshake returns to IDLE and a new
//   frame_sync is needed.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   frame_sync     in   start-of-frame pulse; resynchronises while loading
//   serial_valid   in   serial_in carries a bit this cycle
//   serial_in      in   serial data bit
//   lane_shift_en  out  one-hot shift enable, one cycle after an accepted bit
//   lane_serial    out  registered serial_in, shared by all lanes
//   frame_valid    out  bank holds a complete frame
//   frame_ready    in   FFT core accepts the frame
//   busy           out  state is LOAD or DONE
//   lane_idx       out  lane currently being filled
//   overrun        out  sticky: a bit arrived in DONE and was dropped
//   dbg_state      out  current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a frame transfers on a rising clk edge where frame_valid and
// frame_ready are both high. frame_valid never drops before that transfer,
// and it goes low the cycle after the transfer.
// -----------------------------------------------------------------------------
module stp_load_sequencer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_SAMPLES  = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_sync,
  input  logic                           serial_valid,
  input  logic                           serial_in,
  output logic [NUM_SAMPLES-1:0]         lane_shift_en,
  output logic                           lane_serial,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           busy,
  output logic [$clog2(NUM_SAMPLES)-1:0] lane_idx,
  output logic                           overrun,
  output logic [1:0]                     dbg_state
);

  localparam int CW = $clog2(SAMPLE_WIDTH);
  localparam int LW = $clog2(NUM_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]          lane_idx_q, lane_idx_d;
  logic [NUM_SAMPLES-1:0] shift_en_q, shift_en_d;
  logic                   lane_serial_q, lane_serial_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    lane_idx_d    = lane_idx_q;
    shift_en_d    = '0;
    lane_serial_d = serial_in;
    frame_valid_d = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      S_IDLE: begin
        // A bit arriving with frame_sync is not part of the new frame.
        if (frame_sync) begin
          state_d    = S_LOAD;
          bit_cnt_d  = '0;
          lane_idx_d = '0;
        end
      end

      S_LOAD: begin
        if (frame_sync) begin
          // Resync drops any bit in this cycle and issues no shift.
          bit_cnt_d  = '0;
          lane_idx_d = '0;
        end else if (serial_valid) begin
          shift_en_d[lane_idx_q] = 1'b1;
          if (bit_cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (lane_idx_q == LW'(NUM_SAMPLES - 1)) begin
              // Last bit of the last lane: freeze the bank.
              lane_idx_d = '0;
              state_d    = S_DONE;
            end else begin
              lane_idx_d = lane_idx_q + LW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        // frame_valid lags entry into DONE by one cycle, so it rises the
        // cycle after the final shift pulse.
        if (frame_valid_q && frame_ready) begin
          bit_cnt_d  = '0;
          lane_idx_d = '0;
`ifdef STP_AUTO_REARM_EN
          state_d = S_LOAD;
          if (serial_valid) begin
            shift_en_d[0] = 1'b1;
            bit_cnt_d     = CW'(1);
          end
`else
          state_d = S_IDLE;
          if (serial_valid) begin
            overrun_d = 1'b1;
          end
`endif
        end else begin
          frame_valid_d = 1'b1;
          if (serial_valid) begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      lane_idx_q    <= '0;
      shift_en_q    <= '0;
      lane_serial_q <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      lane_idx_q    <= lane_idx_d;
      shift_en_q    <= shift_en_d;
      lane_serial_q <= lane_serial_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign lane_shift_en = shift_en_q;
  assign lane_serial   = lane_serial_q;
  assign frame_valid   = frame_valid_q;
  assign busy          = busy_q;
  assign lane_idx      = lane_idx_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

endmodule
